// File: rtl/multimode_counter.sv
// multimode_counter: WIDTH-bit counter running binary, ring, Johnson or Gray code,
// with up/down, synchronous load and a combinational terminal-count flag.
module multimode_counter #(
    parameter int         WIDTH    = 4,
    parameter logic [1:0] MODE_RST = 2'b00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic [1:0]       mode_cur
);
    typedef enum logic [1:0] {
        M_BIN  = 2'b00,
        M_RING = 2'b01,
        M_JOHN = 2'b10,
        M_GRAY = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] r_count;
    mode_e            r_mode;

    mode_e            w_mode_in;
    logic             w_mode_chg;
    logic             w_legal;
    logic             w_at_term;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_gbin;
    logic [WIDTH-1:0] w_gstep;

    function automatic logic [WIDTH-1:0] home(input mode_e m);
        return (m == M_RING) ? ONE : '0;
    endfunction

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Valid Johnson codes (0*1* or 1*0*) have at most one adjacent-bit transition.
    function automatic logic john_ok(input logic [WIDTH-1:0] v);
        return $countones(v[WIDTH-1:1] ^ v[WIDTH-2:0]) <= 1;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_mode_in  = mode_e'(mode);
        w_mode_chg = (w_mode_in != r_mode);
        w_legal    = 1'b1;
        w_at_term  = 1'b0;
        w_step     = r_count;
        w_load     = load_val;
        w_gbin     = gray2bin(r_count);
        w_gstep    = up_dn ? w_gbin + ONE : w_gbin - ONE;

        case (r_mode)
            M_BIN: begin
                w_step    = up_dn ? r_count + ONE : r_count - ONE;
                w_at_term = up_dn ? (&r_count) : (r_count == '0);
            end
            M_RING: begin
                w_legal   = $onehot(r_count);
                w_step    = up_dn ? {r_count[WIDTH-2:0], r_count[WIDTH-1]}
                                  : {r_count[0], r_count[WIDTH-1:1]};
                w_at_term = up_dn ? (r_count == MSB_ONLY) : (r_count == ONE);
                w_load    = $onehot(load_val) ? load_val : ONE;
            end
            M_JOHN: begin
                w_legal   = john_ok(r_count);
                w_step    = up_dn ? {r_count[WIDTH-2:0], ~r_count[WIDTH-1]}
                                  : {~r_count[0], r_count[WIDTH-1:1]};
                w_at_term = up_dn ? (r_count == MSB_ONLY) : (r_count == '0);
                w_load    = john_ok(load_val) ? load_val : '0;
            end
            default: begin
                w_step    = w_gstep ^ (w_gstep >> 1);
                w_at_term = up_dn ? (r_count == MSB_ONLY) : (r_count == '0);
            end
        endcase

        // An SEU-corrupted ring/Johnson state recovers to home on the next step.
        if (!w_legal) w_step = home(r_mode);

        if (w_mode_chg)  w_next = home(w_mode_in);
        else if (load)   w_next = w_load;
        else if (en)     w_next = w_step;
        else             w_next = r_count;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            r_mode  <= mode_e'(MODE_RST);
            r_count <= home(mode_e'(MODE_RST));
        end else begin
            r_mode  <= w_mode_in;
            r_count <= w_next;
        end
    end

    assign count    = r_count;
    assign mode_cur = r_mode;
    assign tc       = en & ~rst & ~w_mode_chg & w_legal & w_at_term;

endmodule

// File: tb/tb_multimode_counter.sv
// Directed testbench for multimode_counter (WIDTH=4) covering all four codes,
// load sanitising, priorities, async reset and ring SEU recovery.
module tb_multimode_counter;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         up_dn;
    logic [1:0]   mode;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         tc;
    logic [1:0]   mode_cur;

    int checks   = 0;
    int failures = 0;

    multimode_counter #(.WIDTH(W), .MODE_RST(2'b00)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .mode_cur (mode_cur)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; up_dn = 1'b0; mode = 2'b00; load = 1'b0; load_val = '0;
        #3;
        checks++; if (count !== 4'b0000) begin failures++; $display("FAIL reset_count: got %b exp 0000", count); end
        checks++; if (mode_cur !== 2'b00) begin failures++; $display("FAIL reset_mode: got %b exp 00", mode_cur); end
        checks++; if (tc !== 1'b0) begin failures++; $display("FAIL reset_tc: got %b exp 0", tc); end
        en = 1'b0; up_dn = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_binary;
        en = 1'b1; up_dn = 1'b1; mode = 2'b00;
        #1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (count !== W'(i)) begin failures++; $display("FAIL bin_up_count[%0d]: got %b exp %b", i, count, W'(i)); end
            checks++; if (tc !== (i == 15)) begin failures++; $display("FAIL bin_up_tc[%0d]: got %b exp %b", i, tc, (i == 15)); end
            tick();
        end
        checks++; if (count !== 4'b0000) begin failures++; $display("FAIL bin_wrap: got %b exp 0000", count); end
        up_dn = 1'b0;
        #1;
        checks++; if (tc !== 1'b1) begin failures++; $display("FAIL bin_dn_tc: got %b exp 1", tc); end
        tick();
        checks++; if (count !== 4'b1111) begin failures++; $display("FAIL bin_dn_wrap: got %b exp 1111", count); end
        checks++; if (tc !== 1'b0) begin failures++; $display("FAIL bin_dn_tc15: got %b exp 0", tc); end
        tick();
        checks++; if (count !== 4'b1110) begin failures++; $display("FAIL bin_dn_14: got %b exp 1110", count); end
    endtask

    task automatic test_ring;
        logic [W-1:0] seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [W-1:0] prev;
        mode = 2'b01; up_dn = 1'b1; en = 1'b1;
        #1;
        checks++; if (tc !== 1'b0) begin failures++; $display("FAIL ring_chg_tc: got %b exp 0", tc); end
        tick();
        checks++; if (count !== 4'b0001) begin failures++; $display("FAIL ring_home: got %b exp 0001", count); end
        checks++; if (mode_cur !== 2'b01) begin failures++; $display("FAIL ring_mode: got %b exp 01", mode_cur); end
        prev = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            checks++; if (tc !== (prev == 4'b1000)) begin failures++; $display("FAIL ring_up_tc[%0d]: got %b", i, tc); end
            tick();
            checks++; if (count !== seq[i]) begin failures++; $display("FAIL ring_up[%0d]: got %b exp %b", i, count, seq[i]); end
            prev = seq[i];
        end
        up_dn = 1'b0;
        #1;
        checks++; if (tc !== 1'b1) begin failures++; $display("FAIL ring_dn_tc: got %b exp 1", tc); end
        tick();
        checks++; if (count !== 4'b1000) begin failures++; $display("FAIL ring_dn: got %b exp 1000", count); end
    endtask

    task automatic test_johnson;
        logic [W-1:0] seq [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                  4'b1110, 4'b1100, 4'b1000, 4'b0000};
        logic [W-1:0] prev;
        mode = 2'b10; up_dn = 1'b1; en = 1'b1;
        tick();
        checks++; if (count !== 4'b0000) begin failures++; $display("FAIL john_home: got %b exp 0000", count); end
        checks++; if (mode_cur !== 2'b10) begin failures++; $display("FAIL john_mode: got %b exp 10", mode_cur); end
        prev = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            checks++; if (tc !== (prev == 4'b1000)) begin failures++; $display("FAIL john_up_tc[%0d]: got %b", i, tc); end
            tick();
            checks++; if (count !== seq[i]) begin failures++; $display("FAIL john_up[%0d]: got %b exp %b", i, count, seq[i]); end
            prev = seq[i];
        end
        en = 1'b0; load = 1'b1; load_val = 4'b0101;
        tick();
        checks++; if (count !== 4'b0000) begin failures++; $display("FAIL john_load_bad: got %b exp 0000", count); end
        load_val = 4'b0011;
        tick();
        checks++; if (count !== 4'b0011) begin failures++; $display("FAIL john_load_ok: got %b exp 0011", count); end
        load = 1'b0;
    endtask

    task automatic test_gray;
        logic [W-1:0] seq [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                  4'b0111, 4'b0101, 4'b0100, 4'b1100};
        logic [W-1:0] prev;
        mode = 2'b11; up_dn = 1'b1; en = 1'b1;
        tick();
        checks++; if (count !== 4'b0000) begin failures++; $display("FAIL gray_home: got %b exp 0000", count); end
        prev = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (count !== seq[i]) begin failures++; $display("FAIL gray_up[%0d]: got %b exp %b", i, count, seq[i]); end
            checks++; if ($countones(count ^ prev) != 1) begin failures++; $display("FAIL gray_onebit[%0d]: got %b prev %b", i, count, prev); end
            prev = count;
        end
        en = 1'b0; load = 1'b1; load_val = 4'b0110;
        tick();
        checks++; if (count !== 4'b0110) begin failures++; $display("FAIL gray_load: got %b exp 0110", count); end
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        tick();
        checks++; if (count !== 4'b0010) begin failures++; $display("FAIL gray_dn: got %b exp 0010", count); end
        load = 1'b1; load_val = 4'b1000; up_dn = 1'b1;
        tick();
        checks++; if (count !== 4'b1000) begin failures++; $display("FAIL gray_load_term: got %b exp 1000", count); end
        #1;
        checks++; if (tc !== 1'b1) begin failures++; $display("FAIL gray_tc_on_load: got %b exp 1", tc); end
        load = 1'b0;
        tick();
        checks++; if (count !== 4'b0000) begin failures++; $display("FAIL gray_wrap: got %b exp 0000", count); end
    endtask

    task automatic test_simultaneous;
        mode = 2'b00; load = 1'b1; load_val = 4'b1010; en = 1'b1;
        tick();
        checks++; if (count !== 4'b0000) begin failures++; $display("FAIL sim_mode_load: got %b exp 0000", count); end
        checks++; if (mode_cur !== 2'b00) begin failures++; $display("FAIL sim_mode_cur: got %b exp 00", mode_cur); end
        load_val = 4'b0101;
        tick();
        checks++; if (count !== 4'b0101) begin failures++; $display("FAIL sim_load_en: got %b exp 0101", count); end
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (count !== 4'b0101) begin failures++; $display("FAIL sim_hold[%0d]: got %b exp 0101", i, count); end
        end
        load = 1'b1; load_val = 4'b1001;
        tick();
        load = 1'b0; en = 1'b1;
        checks++; if (count !== 4'b1001) begin failures++; $display("FAIL sim_pre_rst: got %b exp 1001", count); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (count !== 4'b0000) begin failures++; $display("FAIL sim_async_rst: got %b exp 0000", count); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if (count !== 4'b0001) begin failures++; $display("FAIL sim_post_rst: got %b exp 0001", count); end
    endtask

    task automatic test_ring_illegal;
        mode = 2'b01; en = 1'b0; up_dn = 1'b1;
        tick();
        checks++; if (count !== 4'b0001) begin failures++; $display("FAIL ill_home: got %b exp 0001", count); end
        force dut.r_count = 4'b0110;
        #1;
        release dut.r_count;
        en = 1'b1;
        #1;
        checks++; if (count !== 4'b0110) begin failures++; $display("FAIL ill_deposit: got %b exp 0110", count); end
        checks++; if (tc !== 1'b0) begin failures++; $display("FAIL ill_tc: got %b exp 0", tc); end
        tick();
        checks++; if (count !== 4'b0001) begin failures++; $display("FAIL ill_recover: got %b exp 0001", count); end
    endtask

    initial begin
        test_reset();
        test_binary();
        test_ring();
        test_johnson();
        test_gray();
        test_simultaneous();
        test_ring_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
